// File: rtl/dvp_capture.sv
// DVP camera front end: pairs bytes into RGB565, skips warm-up frames, checks line/frame geometry.
// Define DVP_TEST_PATTERN_EN to add tp_sel, which substitutes 8 vertical colour bars for camera data.
module dvp_capture #(
  parameter logic [11:0] H_DISP      = 12'd1280,
  parameter logic [11:0] V_DISP      = 12'd720,
  parameter logic [3:0]  SKIP_FRAMES = 4'd10,
  parameter int unsigned CNT_WIDTH   = 12
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
`ifdef DVP_TEST_PATTERN_EN
  input  logic        tp_sel,
`endif
  input  logic        err_clr,
  output logic        vi_vs,
  output logic        vi_de,
  output logic [15:0] vi_data,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSkip    = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;

  localparam logic [CNT_WIDTH-1:0] HCnt   = CNT_WIDTH'(H_DISP);
  localparam logic [CNT_WIDTH-1:0] VCnt   = CNT_WIDTH'(V_DISP);
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic                 vs_s1_q, vs_s2_q, href_s1_q, href_s2_q;
  logic [7:0]           data_s1_q;
  logic [1:0]           state_q, state_d;
  logic [3:0]           skip_cnt_q, skip_cnt_d, skip_inc;
  logic                 phase_q, phase_d;
  logic [7:0]           hi_q, hi_d;
  logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic                 pix_vld_q, pix_vld_d;
  logic [15:0]          pix_data_q, pix_data_d, pixel;
  logic                 vi_vs_q, vi_vs_d, vi_de_q, vi_de_d;
  logic [15:0]          vi_data_q, vi_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic                 line_set, frame_set;
  logic                 vs_rise, href_fall, capture;

  assign vs_rise   = vs_s1_q & ~vs_s2_q;
  assign href_fall = ~href_s1_q & href_s2_q;
  assign capture   = (state_q == StCapture);
  assign skip_inc  = skip_cnt_q + 4'd1;

`ifdef DVP_TEST_PATTERN_EN
  localparam int unsigned BarW = ((int'(H_DISP) / 8) == 0) ? 1 : (int'(H_DISP) / 8);
  logic [CNT_WIDTH-1:0] bar_pos;
  logic [2:0]           bar_idx;
  logic [15:0]          bar_rgb;

  always_comb begin
    bar_pos = pix_cnt_q / CNT_WIDTH'(BarW);
    bar_idx = (bar_pos > CNT_WIDTH'(7)) ? 3'd7 : bar_pos[2:0];
    unique case (bar_idx)
      3'd0: bar_rgb = 16'hFFFF;
      3'd1: bar_rgb = 16'hFFE0;
      3'd2: bar_rgb = 16'h07FF;
      3'd3: bar_rgb = 16'h07E0;
      3'd4: bar_rgb = 16'hF81F;
      3'd5: bar_rgb = 16'hF800;
      3'd6: bar_rgb = 16'h001F;
      3'd7: bar_rgb = 16'h0000;
    endcase
    pixel = tp_sel ? bar_rgb : {hi_q, data_s1_q};
  end
`else
  assign pixel = {hi_q, data_s1_q};
`endif

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    case (state_q)
      StIdle: begin
        if (en && vs_rise) begin
          skip_cnt_d = 4'd0;
          state_d    = (SKIP_FRAMES == 4'd0) ? StCapture : StSkip;
        end
      end
      StSkip: begin
        if (vs_rise) begin
          skip_cnt_d = skip_inc;
          if (skip_inc == SKIP_FRAMES) state_d = StCapture;
        end
      end
      StCapture: begin
        if (vs_rise && !en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    phase_d      = phase_q;
    hi_d         = hi_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    pix_vld_d    = 1'b0;
    pix_data_d   = pix_data_q;
    frame_done_d = 1'b0;
    line_set     = 1'b0;
    frame_set    = 1'b0;
    if (!capture) begin
      phase_d    = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end else begin
      // Bytes arriving during vsync are not part of any line.
      if (href_s1_q && !vs_s1_q) begin
        if (!phase_q) begin
          hi_d    = data_s1_q;
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          pix_vld_d  = 1'b1;
          pix_data_d = pixel;
          if (pix_cnt_q != CntMax) pix_cnt_d = pix_cnt_q + CNT_WIDTH'(1);
        end
      end else if (href_fall && !vs_s2_q) begin
        line_set  = phase_q || (pix_cnt_q != HCnt);
        phase_d   = 1'b0;
        pix_cnt_d = '0;
        if (line_cnt_q != CntMax) line_cnt_d = line_cnt_q + CNT_WIDTH'(1);
      end
      // The edge that moved us into capture was seen in the previous state, so never pulses here.
      if (vs_rise) begin
        frame_done_d = 1'b1;
        frame_set    = (line_cnt_q != VCnt);
        line_cnt_d   = '0;
      end
    end
  end

  always_comb begin
    vi_vs_d     = capture & vs_s2_q;
    vi_de_d     = pix_vld_q;
    vi_data_d   = pix_vld_q ? pix_data_q : vi_data_q;
    line_err_d  = err_clr ? 1'b0 : (line_err_q | line_set);
    frame_err_d = err_clr ? 1'b0 : (frame_err_q | frame_set);
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      href_s1_q    <= 1'b0;
      href_s2_q    <= 1'b0;
      data_s1_q    <= 8'd0;
      state_q      <= StIdle;
      skip_cnt_q   <= 4'd0;
      phase_q      <= 1'b0;
      hi_q         <= 8'd0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      pix_vld_q    <= 1'b0;
      pix_data_q   <= 16'd0;
      vi_vs_q      <= 1'b0;
      vi_de_q      <= 1'b0;
      vi_data_q    <= 16'd0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      vs_s1_q      <= cam_vsync;
      vs_s2_q      <= vs_s1_q;
      href_s1_q    <= cam_href;
      href_s2_q    <= href_s1_q;
      data_s1_q    <= cam_data;
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      pix_vld_q    <= pix_vld_d;
      pix_data_q   <= pix_data_d;
      vi_vs_q      <= vi_vs_d;
      vi_de_q      <= vi_de_d;
      vi_data_q    <= vi_data_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign vi_vs      = vi_vs_q;
  assign vi_de      = vi_de_q;
  assign vi_data    = vi_data_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign frame_err  = frame_err_q;

endmodule
